// File: rtl/mix_pkg.sv
// Shared widths, Q1.23 limits and the frame tag carried alongside the multiplier.
package mix_pkg;
  localparam int SAMPLE_W = 24;
  localparam logic [SAMPLE_W-1:0] Q123_MAX = 24'h7fffff;
  localparam logic [SAMPLE_W-1:0] Q123_MIN = 24'h800000;

  typedef struct packed {
    logic issue;
    logic first;
    logic last;
  } tag_t;
endpackage

// File: rtl/mixacc_tagdly.sv
// Matched delay line for frame tags; mirrors the multiplier's fixed latency.
module mixacc_tagdly
  import mix_pkg::*;
#(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_i,
  output tag_t tag_o
);
  tag_t [DEPTH-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_o = pipe[DEPTH-1];
endmodule

// File: rtl/mixacc.sv
// Frame mixer: sums aligned multiplier products with guard bits, saturates to Q1.23
// on the last channel and presents the sample through a valid/ack holding register.
module mixacc
  import mix_pkg::*;
#(
  parameter int MP_LATENCY = 5,
  parameter int GUARD      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_i,
  input  logic                first_i,
  input  logic                last_i,
  input  logic [SAMPLE_W-1:0] mprod_i,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                valid_o,
  input  logic                ack_i,
  output logic                clip_o,
  output logic                overrun_o,
  output logic                frame_err_o
);
  localparam int ACC_W = SAMPLE_W + GUARD;

  // Async assert, sync release of the internal reset.
  logic [1:0] rst_sync;
  logic       rst_l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_l = rst_sync[1];

  tag_t tag_in, tag_al;

  assign tag_in = '{issue: issue_i, first: first_i & issue_i, last: last_i & issue_i};

  mixacc_tagdly #(.DEPTH(MP_LATENCY)) u_tagdly (
    .clk   (clk),
    .rst_n (rst_l),
    .tag_i (tag_in),
    .tag_o (tag_al)
  );

  logic [ACC_W-1:0]    acc, acc_next, p;
  logic                open, open_next;
  logic                err_set, done;
  logic                fits, sat_clip;
  logic [SAMPLE_W-1:0] sat_s;

  assign p = {{GUARD{mprod_i[SAMPLE_W-1]}}, mprod_i};

  always_comb begin
    acc_next  = acc;
    open_next = open;
    err_set   = 1'b0;
    done      = 1'b0;
    if (tag_al.issue) begin
      if (tag_al.first) begin
        acc_next  = p;
        err_set   = open;
        open_next = 1'b1;
      end else if (open) begin
        acc_next = acc + p;
      end else begin
        err_set = 1'b1;
      end
      // A stray last with no open frame is ignored along with its product.
      if (tag_al.last && (tag_al.first || open)) begin
        done      = 1'b1;
        open_next = 1'b0;
      end
    end
  end

  // In range iff every bit from the Q1.23 sign upward agrees.
  always_comb begin
    fits     = (acc_next[ACC_W-1:SAMPLE_W-1] == '0) || (acc_next[ACC_W-1:SAMPLE_W-1] == '1);
    sat_clip = ~fits;
    if (fits)                  sat_s = acc_next[SAMPLE_W-1:0];
    else if (acc_next[ACC_W-1]) sat_s = Q123_MIN;
    else                       sat_s = Q123_MAX;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      acc  <= '0;
      open <= 1'b0;
    end else begin
      acc  <= acc_next;
      open <= open_next;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sample_o    <= '0;
      valid_o     <= 1'b0;
      clip_o      <= 1'b0;
      overrun_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      clip_o <= done & sat_clip;
      if (err_set) frame_err_o <= 1'b1;
      if (done) begin
        if (!valid_o || ack_i) begin
          sample_o <= sat_s;
          valid_o  <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (ack_i) begin
        valid_o <= 1'b0;
      end
    end
  end
endmodule
